// File: rtl/spike_mon_pkg.sv
// Shared types for the spike rate monitor: counter width, FSM states and the FIFO entry layout.
// The peak field exists only when SPIKE_MON_PEAK_EN is defined.
package spike_mon_pkg;

    localparam int COUNT_W = 8;
    localparam int PEAK_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLOSE = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
`ifdef SPIKE_MON_PEAK_EN
        logic [PEAK_W-1:0]  peak;
`endif
    } fifo_entry_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] val);
        logic [COUNT_W-1:0] res;
        if (val == {COUNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/spike_rate_monitor_if.sv
// Result stream from the spike rate monitor: head of the result FIFO with valid/ready handshake.
interface spike_rate_monitor_if;
    logic [7:0] out_count;
    logic [7:0] out_peak;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_count, output out_peak, output out_valid, input out_ready);
    modport slave  (input out_count, input out_peak, input out_valid, output out_ready);
endinterface

// File: rtl/spike_mon_fifo.sv
// Synchronous result FIFO with full/empty flags and a sticky overflow flag.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module spike_mon_fifo
    import spike_mon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output fifo_entry_t dout,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        overflow_r;
    logic        do_pop_s;
    logic        do_push_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign overflow  = overflow_r;
    assign dout      = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

    // Storage, pointers and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (push && full && !do_pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// Counts rising crossings of v_mem over THRESH in fixed windows and queues one result per window.
// Define SPIKE_MON_PEAK_EN to also track and report the per-window peak of v_mem.
module spike_rate_monitor
    import spike_mon_pkg::*;
#(
    parameter logic [7:0] THRESH     = 8'd128,
    parameter int         WINDOW_LEN = 256,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [7:0]                  v_mem,
    spike_rate_monitor_if.master        out_if,
    output logic                        overflow,
    output logic                        spike
);

    localparam logic [15:0] WIN_LAST = 16'(WINDOW_LEN - 1);

    mon_state_e         state_r;
    mon_state_e         state_nxt_s;
    logic [7:0]         v_q_r;
    logic               above_r;
    logic               spike_r;
    logic [15:0]        win_cnt_r;
    logic [15:0]        win_cnt_nxt_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] count_nxt_s;
    logic               push_s;
    fifo_entry_t        entry_s;
    fifo_entry_t        head_s;
    logic               full_s;
    logic               empty_s;

    // Input sample and rising-crossing detector; spike follows the crossing sample by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q_r   <= 8'h00;
            above_r <= 1'b0;
            spike_r <= 1'b0;
        end else begin
            v_q_r   <= v_mem;
            above_r <= (v_q_r >= THRESH);
            spike_r <= (v_q_r >= THRESH) && !above_r;
        end
    end

    // Window FSM state, window counter and spike count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            win_cnt_r <= 16'd0;
            count_r   <= '0;
        end else begin
            state_r   <= state_nxt_s;
            win_cnt_r <= win_cnt_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    // Next-state logic; dropping en in RUN abandons the partial window without a push
    always_comb begin
        state_nxt_s   = state_r;
        win_cnt_nxt_s = 16'd0;
        count_nxt_s   = '0;
        push_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    count_nxt_s = spike_r ? sat_inc(count_r) : count_r;
                    if (win_cnt_r == WIN_LAST) begin
                        state_nxt_s = ST_CLOSE;
                    end else begin
                        win_cnt_nxt_s = win_cnt_r + 16'd1;
                    end
                end
            end
            ST_CLOSE: begin
                push_s = 1'b1;
                if (en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

`ifdef SPIKE_MON_PEAK_EN
    logic [PEAK_W-1:0] peak_r;
    logic [PEAK_W-1:0] peak_nxt_s;

    // Running maximum over RUN cycles; cleared everywhere else, including after the CLOSE push
    always_comb begin
        if (state_r == ST_RUN && en) begin
            peak_nxt_s = (v_q_r > peak_r) ? v_q_r : peak_r;
        end else begin
            peak_nxt_s = 8'h00;
        end
    end

    // Peak register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_r <= 8'h00;
        end else begin
            peak_r <= peak_nxt_s;
        end
    end

    assign entry_s.peak    = peak_r;
    assign out_if.out_peak = head_s.peak;
`else
    assign out_if.out_peak = 8'h00;
`endif

    assign entry_s.count = count_r;

    spike_mon_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .din      (entry_s),
        .pop      (out_if.out_ready),
        .dout     (head_s),
        .full     (full_s),
        .empty    (empty_s),
        .overflow (overflow)
    );

    assign out_if.out_valid = !empty_s;
    assign out_if.out_count = head_s.count;
    assign spike            = spike_r;

endmodule

// File: doc/spike_rate_monitor.md
SPIKE_RATE_MONITOR -- requirements
Module: spike_rate_monitor

Interface
REQ-001 SHALL have parameter THRESH, default 8'd128: V_mem level that constitutes a spike.
REQ-002 SHALL have parameter WINDOW_LEN, default 256: clock cycles per counting window, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries, power of two.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1 bit: monitoring enable.
REQ-007 SHALL have port v_mem, input, 8 bits: membrane value from the last neuron stage.
REQ-008 SHALL have port out_count, output, 8 bits: spikes counted in one completed window.
REQ-009 SHALL have port out_peak, output, 8 bits: maximum v_mem seen in that window.
REQ-010 SHALL have port out_valid, output, 1 bit: FIFO head is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a dropped window result.
REQ-013 SHALL have port spike, output, 1 bit: registered single-cycle spike pulse.

Function
REQ-014 SHALL register v_mem once, as v_q, and detect a spike when v_q >= THRESH while the previous v_q < THRESH (rising crossing only).
REQ-015 SHALL assert spike for exactly one cycle, one cycle after the crossing sample; a sustained level above THRESH yields one spike.
REQ-016 SHALL implement FSM IDLE/RUN/CLOSE: IDLE->RUN when en=1; RUN->CLOSE when the window counter reaches WINDOW_LEN-1; CLOSE->RUN when en=1, else CLOSE->IDLE.
REQ-017 SHALL push {count, peak} into the FIFO in CLOSE, then clear count and peak in the same cycle; CLOSE lasts one cycle and is not counted in the window.
REQ-018 SHALL saturate count at 8'hFF and SHALL not wrap.
REQ-019 SHALL, on en deassertion while in RUN, discard the partial window, clear the counters, and enter IDLE on the next edge without pushing.
REQ-020 SHALL transfer the FIFO head when out_valid and out_ready are both 1; out_count and out_peak SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on a push with the FIFO full and no pop in the same cycle, drop the new result and set overflow; overflow clears only on rst.
REQ-022 SHALL, on a simultaneous push and pop with the FIFO full, accept the push and not set overflow.
REQ-023 SHALL count a spike that occurs in the last RUN cycle in the closing window.

Reset
REQ-024 SHALL, on rst, asynchronously force the FSM to IDLE, v_q to 0, count, peak and window counter to 0, the FIFO to empty, and out_valid, spike and overflow to 0.
REQ-025 SHALL drive out_count=0 and out_peak=0 while the FIFO is empty.
REQ-026 SHALL, on rst asserted mid-window, discard all buffered and partial results.

Configuration
REQ-027 SHALL, with SPIKE_MON_PEAK_EN defined, track the per-window maximum of v_q and store it alongside count.
REQ-028 SHALL, with SPIKE_MON_PEAK_EN undefined, omit peak storage from the FIFO and tie out_peak to 8'h00.

Structure
REQ-029 SHALL place COUNT_W, the FSM state enum, and the FIFO entry struct in package spike_mon_pkg.
REQ-030 SHALL implement the buffer as sub-module spike_mon_fifo, a synchronous FIFO with full/empty flags and async reset.

Verification
REQ-031 SHALL cover: WINDOW_LEN=16, THRESH=128, v_mem toggling 0/200 every 2 cycles, out_ready=1 -> out_count=4, out_peak=200 per window.
REQ-032 SHALL cover: v_mem held at 255 for a full window -> exactly one spike, out_count=1.
REQ-033 SHALL cover: out_ready=0 for 6 windows with FIFO_DEPTH=4 -> 4 entries retained, overflow=1, first 4 counts drain in order.
REQ-034 SHALL cover: en dropped mid-window after 3 spikes -> no push, FSM IDLE; a re-enabled window counts from 0.
REQ-035 SHALL cover: 300 crossings in one window (WINDOW_LEN=1024) -> out_count=255.
REQ-036 SHALL cover: rst pulse with 2 FIFO entries pending -> out_valid=0 immediately, overflow=0.
